// File: rtl/lane_pkg.sv
// Shared definitions for the lane phase sequencer: FSM state codes,
// per-direction light codes, common patterns and pattern helpers.
// Patterns use WWSSEENN order, two bits per direction.
package lane_pkg;

  // Phase state; the encoding is visible on the phase output.
  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    CLEAR  = 2'd3
  } state_e;

  // Per-direction light codes (10 is illegal).
  localparam logic [1:0] DIR_GREEN  = 2'b11;
  localparam logic [1:0] DIR_YELLOW = 2'b01;
  localparam logic [1:0] DIR_RED    = 2'b00;

  // Whole-junction patterns.
  localparam logic [7:0] PAT_NS     = 8'b0011_0011;
  localparam logic [7:0] PAT_EW     = 8'b1100_1100;
  localparam logic [7:0] PAT_ALLRED = 8'b0000_0000;

  // Width of the phase counter and of the duration fields.
  localparam int unsigned CNT_W = 7;

  // Keep only directions requested green; anything else (yellow or the
  // illegal code) is captured as red so a request can never start amber.
  function automatic logic [7:0] sanitise(input logic [7:0] pattern);
    logic [7:0] clean;
    clean = PAT_ALLRED;
    for (int d = 0; d < 4; d++) begin
      if (pattern[2*d +: 2] == DIR_GREEN) clean[2*d +: 2] = DIR_GREEN;
    end
    return clean;
  endfunction

  // Turn every green direction amber; all other directions are red.
  function automatic logic [7:0] to_yellow(input logic [7:0] pattern);
    logic [7:0] amber;
    amber = PAT_ALLRED;
    for (int d = 0; d < 4; d++) begin
      if (pattern[2*d +: 2] == DIR_GREEN) amber[2*d +: 2] = DIR_YELLOW;
    end
    return amber;
  endfunction

  // A zero duration would never expire, so it is promoted to one tick.
  function automatic logic [CNT_W-1:0] sanitise_time(input logic [CNT_W-1:0] ticks);
    return (ticks == '0) ? CNT_W'(1) : ticks;
  endfunction

endpackage

// File: rtl/lane_phase_sequencer_phase_counter.sv
// phase_counter: loadable down-counter timing one phase in ticks.
// It holds at 1 until the tick that ends the phase; done marks that tick
// so the owner reloads it on the same edge.
module phase_counter
  import lane_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: a load wins; otherwise step down on tick while above 1.
  always_comb begin
    // NOTE: default assignment first so every path drives count_d (no latch).
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q > CNT_W'(1))) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment to avoid ordering races.
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;
  assign done_o  = tick_i && (count_q == CNT_W'(1));

endmodule

// File: rtl/lane_phase_sequencer.sv
// lane_phase_sequencer: accepts a lane request from the mode logic, holds
// it green for the requested ticks, then runs yellow and (optionally)
// all-red clearance before accepting the next request. A request equal to
// the current green pattern at expiry extends green without a yellow.
// Build option: define LANE_ALLRED_EN to include the all-red CLEAR phase;
// without it YELLOW expiry returns straight to LOAD.
module lane_phase_sequencer
  import lane_pkg::*;
#(
  parameter int unsigned YELLOW_TICKS = 4,
  parameter int unsigned ALLRED_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [7:0]       laneRequest,
  input  logic [CNT_W-1:0] loadTime,
  output logic [7:0]       lightState,
  output logic [CNT_W-1:0] timeRemaining,
  output logic             loadStrobe,
  output logic [1:0]       phase
);

`ifdef LANE_ALLRED_EN
  localparam bit ALLRED_EN = 1'b1;
`else
  localparam bit ALLRED_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] YELLOW_CNT = CNT_W'(YELLOW_TICKS);
  localparam logic [CNT_W-1:0] ALLRED_CNT = CNT_W'(ALLRED_TICKS);

  state_e           state_q;
  state_e           state_d;
  logic [7:0]       light_q;
  logic [7:0]       light_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_done;
  logic [7:0]       req_clean;

  assign req_clean = sanitise(laneRequest);

  phase_counter u_counter (
    .clk        (clk),
    .rst        (rst),
    .tick_i     (tick),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .count_o    (cnt_value),
    .done_o     (cnt_done)
  );

  // Next state, next lights and counter reload for each phase.
  always_comb begin
    state_d  = state_q;
    light_d  = light_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      LOAD: begin
        // Lights keep their previous value during this cycle; the new
        // pattern appears together with the GREEN phase code.
        state_d  = GREEN;
        light_d  = req_clean;
        cnt_load = 1'b1;
        cnt_val  = sanitise_time(loadTime);
      end
      GREEN: begin
        if (cnt_done) begin
          cnt_load = 1'b1;
          if (req_clean == light_q) begin
            // Same pattern requested again: re-load without any amber.
            state_d = LOAD;
            cnt_val = '0;
          end else begin
            state_d = YELLOW;
            cnt_val = YELLOW_CNT;
            light_d = to_yellow(light_q);
          end
        end
      end
      YELLOW: begin
        if (cnt_done) begin
          cnt_load = 1'b1;
          light_d  = PAT_ALLRED;
          if (ALLRED_EN) begin
            state_d = CLEAR;
            cnt_val = ALLRED_CNT;
          end else begin
            // No clearance phase: amber ends in red while the next
            // request is captured.
            state_d = LOAD;
            cnt_val = '0;
          end
        end
      end
      CLEAR: begin
        if (cnt_done) begin
          state_d  = LOAD;
          cnt_load = 1'b1;
          cnt_val  = '0;
        end
      end
      default: begin
        state_d = LOAD;
        light_d = PAT_ALLRED;
      end
    endcase
  end

  // State and light registers; reset drops every direction to red at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      light_q <= PAT_ALLRED;
    end else begin
      state_q <= state_d;
      light_q <= light_d;
    end
  end

  assign lightState    = light_q;
  assign timeRemaining = cnt_value;
  assign phase         = state_q;
  // The capture strobe is quiet while reset holds the FSM in LOAD.
  assign loadStrobe    = (state_q == LOAD) && !rst;

endmodule

// File: tb/tb_lane_phase_sequencer.sv
// Bench for lane_phase_sequencer: a table of per-cycle vectors, a few
// hand-written multi-cycle sequences, and a randomized run compared with
// a segment-list model of the phase plan.
module tb_lane_phase_sequencer;

  localparam int YT = 4;
  localparam int AT = 2;
  localparam logic [7:0] NS  = 8'h33;
  localparam logic [7:0] EW  = 8'hCC;
  localparam logic [7:0] RED = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] laneRequest = 8'h00;
  logic [6:0] loadTime = 7'd0;
  logic [7:0] lightState;
  logic [6:0] timeRemaining;
  logic       loadStrobe;
  logic [1:0] phase;

  lane_phase_sequencer #(.YELLOW_TICKS(YT), .ALLRED_TICKS(AT)) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .laneRequest   (laneRequest),
    .loadTime      (loadTime),
    .lightState    (lightState),
    .timeRemaining (timeRemaining),
    .loadStrobe    (loadStrobe),
    .phase         (phase)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         tk;
    logic [7:0] req;
    logic [6:0] lt;
    logic [7:0] light;
    logic [1:0] ph;
    logic [6:0] rem;
    bit         st;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit tk, input logic [7:0] req, input logic [6:0] lt,
                     input logic [7:0] light, input logic [1:0] ph, input logic [6:0] rem,
                     input bit st);
    vec_t v;
    v.tk = tk; v.req = req; v.lt = lt; v.light = light; v.ph = ph; v.rem = rem; v.st = st;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // The plan is a queue of remaining phases; an empty plan means the
  // sequencer is waiting to capture a request.
  typedef struct {
    int         code;
    logic [7:0] light;
    int         ticks;
  } seg_t;
  seg_t       plan[$];
  logic [7:0] m_light;

  function automatic logic [7:0] clean(input logic [7:0] p);
    int v = 0;
    for (int d = 0; d < 4; d++)
      if (((p >> (2*d)) & 8'h3) == 8'h3) v += 3 << (2*d);
    return 8'(v);
  endfunction

  function automatic logic [7:0] amber(input logic [7:0] p);
    int v = 0;
    for (int d = 0; d < 4; d++)
      if (((p >> (2*d)) & 8'h3) == 8'h3) v += 1 << (2*d);
    return 8'(v);
  endfunction

  task automatic model_step(input bit tk, input logic [7:0] req, input logic [6:0] lt);
    seg_t s;
    seg_t n;
    if (plan.size() == 0) begin
      s.code = 1; s.light = clean(req); s.ticks = (lt == 0) ? 1 : int'(lt);
      plan.push_back(s);
      m_light = s.light;
    end else if (tk) begin
      s = plan[0];
      if (s.ticks > 1) begin
        s.ticks--;
        plan[0] = s;
      end else begin
        void'(plan.pop_front());
        if (s.code == 1 && clean(req) != s.light) begin
          n.code = 2; n.light = amber(s.light); n.ticks = YT;
          plan.push_back(n);
`ifdef LANE_ALLRED_EN
          n.code = 3; n.light = RED; n.ticks = AT;
          plan.push_back(n);
`endif
        end
        if (plan.size() > 0) m_light = plan[0].light;
        else if (s.code != 1) m_light = RED;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    #2;
    check("reset_light", 32'(lightState), 32'(RED));
    check("reset_rem", 32'(timeRemaining), 32'd0);
    check("reset_strobe", 32'(loadStrobe), 32'd0);
    check("reset_phase", 32'(phase), 32'd0);

    // ---- table: NS for 5, amber, clearance, zero duration, skips ----
    add(1, NS, 5, RED, 0, 0, 1);
    for (int k = 5; k >= 1; k--) add(1, EW, 0, NS, 1, 7'(k), 0);
    for (int k = YT; k >= 1; k--) add(1, EW, 0, 8'h11, 2, 7'(k), 0);
`ifdef LANE_ALLRED_EN
    for (int k = AT; k >= 1; k--) add(1, EW, 0, RED, 3, 7'(k), 0);
`endif
    add(1, EW, 0, RED, 0, 0, 1);            // loadTime 0 -> one tick
    add(1, NS, 0, EW, 1, 1, 0);
    for (int k = YT; k >= 1; k--) add(1, 8'hAA, 0, 8'h44, 2, 7'(k), 0);
`ifdef LANE_ALLRED_EN
    for (int k = AT; k >= 1; k--) add(1, 8'hAA, 0, RED, 3, 7'(k), 0);
`endif
    add(1, 8'hAA, 3, RED, 0, 0, 1);         // illegal codes captured as red
    for (int k = 3; k >= 1; k--) add(1, 8'hAA, 0, RED, 1, 7'(k), 0);
    add(1, NS, 1, RED, 0, 0, 1);            // skipped straight back to LOAD
    add(1, NS, 0, NS, 1, 1, 0);
    add(1, EW, 1, NS, 0, 0, 1);             // green held through LOAD
    add(1, 8'hFF, 0, EW, 1, 1, 0);
    for (int k = YT; k >= 1; k--) add(1, 8'hFF, 0, 8'h44, 2, 7'(k), 0);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      tick = vecs[i].tk;
      laneRequest = vecs[i].req;
      loadTime = vecs[i].lt;
      #1;
      check($sformatf("vec%0d_light", i), 32'(lightState), 32'(vecs[i].light));
      check($sformatf("vec%0d_phase", i), 32'(phase), 32'(vecs[i].ph));
      check($sformatf("vec%0d_rem", i), 32'(timeRemaining), 32'(vecs[i].rem));
      check($sformatf("vec%0d_strobe", i), 32'(loadStrobe), 32'(vecs[i].st));
      @(negedge clk);
    end

    // ---- night-time: constant EW for 20 ticks keeps green ----
    do_reset();
    laneRequest = EW; loadTime = 7'd20; tick = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      check($sformatf("night%0d_strobe", i), 32'(loadStrobe), (i % 21 == 0) ? 32'd1 : 32'd0);
      check($sformatf("night%0d_phase", i), 32'(phase), (i % 21 == 0) ? 32'd0 : 32'd1);
      if (i > 0) check($sformatf("night%0d_light", i), 32'(lightState), 32'(EW));
      @(negedge clk);
    end

    // ---- tick every third cycle, loadTime 2 ----
    do_reset();
    laneRequest = NS; loadTime = 7'd2; tick = 1'b1;   // tick in LOAD is ignored
    #1 check("slow_load_strobe", 32'(loadStrobe), 32'd1);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      tick = (k % 3 == 2);
      laneRequest = EW;
      #1;
      check($sformatf("slow%0d_rem", k), 32'(timeRemaining), (k < 3) ? 32'd2 : 32'd1);
      check($sformatf("slow%0d_light", k), 32'(lightState), 32'(NS));
      @(negedge clk);
    end
    tick = 1'b0;
    #1;
    check("slow_end_phase", 32'(phase), 32'd2);
    check("slow_end_light", 32'(lightState), 32'h11);
    check("slow_end_rem", 32'(timeRemaining), 32'(YT));

    // ---- reset asserted during yellow ----
    do_reset();
    laneRequest = NS; loadTime = 7'd1; tick = 1'b1;
    @(negedge clk);
    laneRequest = EW;
    @(negedge clk);
    #1;
    check("rstmid_yellow_phase", 32'(phase), 32'd2);
    check("rstmid_yellow_light", 32'(lightState), 32'h11);
    #2 rst = 1'b1;
    #1;
    check("rstmid_light", 32'(lightState), 32'(RED));
    check("rstmid_phase", 32'(phase), 32'd0);
    check("rstmid_rem", 32'(timeRemaining), 32'd0);
    check("rstmid_strobe", 32'(loadStrobe), 32'd0);
    laneRequest = NS;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rstmid_release_strobe", 32'(loadStrobe), 32'd1);
    @(negedge clk);
    #1;
    check("rstmid_release_phase", 32'(phase), 32'd1);
    check("rstmid_release_light", 32'(lightState), 32'(NS));

    // ---- randomized run against the plan model ----
    do_reset();
    plan.delete();
    m_light = RED;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int sel;
      tick = ($urandom_range(0, 3) != 0);
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: laneRequest = NS;
        1: laneRequest = EW;
        2: laneRequest = 8'($urandom);
        3: laneRequest = RED;
        default: laneRequest = m_light;
      endcase
      loadTime = 7'($urandom_range(0, 6));
      #1;
      check("rand_light", 32'(lightState), 32'(m_light));
      check("rand_phase", 32'(phase), (plan.size() > 0) ? 32'(plan[0].code) : 32'd0);
      check("rand_rem", 32'(timeRemaining), (plan.size() > 0) ? 32'(plan[0].ticks) : 32'd0);
      check("rand_strobe", 32'(loadStrobe), (plan.size() == 0) ? 32'd1 : 32'd0);
      @(posedge clk);
      model_step(tick, laneRequest, loadTime);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
